// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared types for the pulse stream generator: the state encoding constants
// and the FSM state enum used by pulse_stream_gen.
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

  // State encodings are kept as named constants so other blocks (debug
  // taps, checkers) can decode the state bus without the enum type.
  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_STRT_ENC = 3'd1;
  localparam logic [2:0] ST_EMIT_ENC = 3'd2;
  localparam logic [2:0] ST_WAIT_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE_ENC,
    STRT   = ST_STRT_ENC,
    EMIT   = ST_EMIT_ENC,
    WAIT_G = ST_WAIT_ENC,
    DONE   = ST_DONE_ENC
  } pulse_state_e;

  // Width of a down-counter able to hold (limit-1); at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/pulse_down_cnt.sv
// -----------------------------------------------------------------------------
// pulse_down_cnt
// Loadable saturating down-counter with a zero flag. Used both for the
// remaining-pulse count and for the WAIT_G timeout counter.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count -> 0)
//   load_i       load load_val_i (takes priority over dec_i)
//   load_val_i   value to load
//   dec_i        decrement enable; holds at zero instead of wrapping
//   zero_o       high while the count is zero
// -----------------------------------------------------------------------------
module pulse_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, saturating decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pulse_stream_gen.sv
// -----------------------------------------------------------------------------
// pulse_stream_gen
// Launches a stream of `count` pulses on x_out after a one-cycle s_out strobe,
// then waits up to TIMEOUT cycles for the downstream counter's g_in
// acknowledge. Acknowledged streams give a one-cycle done strobe; timeouts and
// premature acknowledges set the sticky err flag.
//
// Configuration macro: PULSE_GAP_EN -- when defined, one x_out=0 cycle is
// inserted between consecutive pulses (N pulses span 2N-1 cycles).
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   start   launch request, sampled only in IDLE
//   count   number of pulses, latched on an accepted start
//   g_in    completion acknowledge from the downstream counter
//   s_out   one-cycle start strobe
//   x_out   pulse stream
//   busy    high outside IDLE
//   done    one-cycle strobe on an acknowledged stream
//   err     sticky error, cleared by the next accepted start
//
// All outputs are registered from next-state values so they line up with
// the state they describe.
// -----------------------------------------------------------------------------
module pulse_stream_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             g_in,
  output logic             s_out,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WAIT_W = cnt_width(TIMEOUT);

  pulse_state_e state_q, state_d;
  logic         err_q, err_d;
  logic         s_q, x_q, busy_q, done_q;
  logic         x_d;

  logic rem_load, rem_dec, rem_zero;
  logic wait_load, wait_dec, wait_zero;

`ifdef PULSE_GAP_EN
  logic gap_q, gap_d;
`endif

  // Remaining-pulse counter. STRT pre-decrements, so EMIT runs while the
  // count walks N-1 .. 0 and leaves on the pulse where it reads zero.
  pulse_down_cnt #(.W(CNT_W)) u_rem_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (rem_load),
    .load_val_i (count),
    .dec_i      (rem_dec),
    .zero_o     (rem_zero)
  );

  // Wait counter: loaded with TIMEOUT-1 on entry to WAIT_G, so reaching zero
  // marks the TIMEOUT-th WAIT_G cycle (g_in is still honoured in that cycle).
  pulse_down_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wait_load),
    .load_val_i (WAIT_W'(TIMEOUT - 1)),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  // Next-state, counter control and error logic.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rem_load  = 1'b0;
    rem_dec   = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
`ifdef PULSE_GAP_EN
    gap_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // g_in is deliberately not examined here.
        if (start) begin
          rem_load = 1'b1;
          err_d    = 1'b0;
          state_d  = STRT;
        end else begin
          state_d  = IDLE;
        end
      end
      STRT: begin
        if (g_in) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rem_zero) begin
          wait_load = 1'b1;
          state_d   = WAIT_G;
        end else begin
          rem_dec = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
`ifdef PULSE_GAP_EN
        if (g_in) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (gap_q) begin
          state_d = EMIT;
        end else if (rem_zero) begin
          wait_load = 1'b1;
          state_d   = WAIT_G;
        end else begin
          rem_dec = 1'b1;
          gap_d   = 1'b1;
          state_d = EMIT;
        end
`else
        if (g_in) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rem_zero) begin
          wait_load = 1'b1;
          state_d   = WAIT_G;
        end else begin
          rem_dec = 1'b1;
          state_d = EMIT;
        end
`endif
      end
      WAIT_G: begin
        if (g_in) begin
          state_d = DONE;
        end else if (wait_zero) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_dec = 1'b1;
          state_d  = WAIT_G;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pulse output decode: high in EMIT except on gap cycles.
  always_comb begin
`ifdef PULSE_GAP_EN
    x_d = (state_d == EMIT) && !gap_d;
`else
    x_d = (state_d == EMIT);
`endif
  end

  // State, sticky error and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      s_q     <= 1'b0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      s_q     <= (state_d == STRT);
      x_q     <= x_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef PULSE_GAP_EN
  // Gap phase flag: set for the idle cycle following each non-final pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign s_out = s_q;
  assign x_out = x_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_pulse_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_stream_gen
// Self-checking bench for pulse_stream_gen. Each cycle the expected output
// vector {s_out,x_out,busy,done,err} is queued as the stimulus is driven and
// popped for comparison one time unit after the clock edge. Expected traces
// are built from the scenario parameters (pulse count, acknowledge slot,
// abort point). Honours PULSE_GAP_EN for the expected pulse pattern.
// -----------------------------------------------------------------------------
module tb_pulse_stream_gen;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
`ifdef PULSE_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             g_in  = 1'b0;
  logic             s_out, x_out, busy, done, err;

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  pulse_stream_gen #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .count (count),
    .g_in  (g_in),
    .s_out (s_out),
    .x_out (x_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs_vec();
    return {s_out, x_out, busy, done, err};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: s/x/busy/done/err got=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic cycle(input string tag, input logic st, input logic [CNT_W-1:0] cnt,
                       input logic g, input logic [4:0] exp);
    start = st;
    count = cnt;
    g_in  = g;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, obs_vec(), exp_q.pop_front());
  endtask

  // One stream. Edge k=1 accepts the start. gj = WAIT_G cycle index in which
  // g_in is raised (<0 or >=TIMEOUT: never). abort_k>0 raises g_in before edge
  // abort_k instead. restart_k>0 issues a second start before that edge.
  task automatic stream(input string name, input int n, input int gj, input int abort_k,
                        input int restart_k, input logic [CNT_W-1:0] restart_cnt,
                        input logic g_with_start);
    int e, kend, total;
    bit good;
    logic [4:0] exp;
    logic st, g, xs;
    logic [CNT_W-1:0] cnt;
    e = (n == 0) ? 0 : (GAP ? 2 * n - 1 : n);
    if (gj >= 0 && gj < TIMEOUT) begin
      kend = 2 + e + gj + 1;
      good = 1'b1;
    end else begin
      kend = 2 + e + TIMEOUT;
      good = 1'b0;
    end
    if (abort_k > 0) begin
      kend = abort_k;
      good = 1'b0;
    end
    total = kend + 2;
    for (int k = 1; k <= total; k++) begin
      xs = (k >= 2) && (k < 2 + e) && (!GAP || ((k - 2) % 2 == 0));
      if (k < kend) exp = {(k == 1), xs, 1'b1, 1'b0, 1'b0};
      else if (k == kend) exp = good ? 5'b00110 : 5'b00001;
      else exp = {4'b0000, !good};
      st  = (k == 1) || (k == restart_k);
      cnt = (k == 1) ? n[CNT_W-1:0] : restart_cnt;
      g   = ((k == 1) && g_with_start) || (abort_k == k) || (good && (k == kend));
      cycle($sformatf("%s k=%0d", name, k), st, cnt, g, exp);
    end
    start = 1'b0;
    g_in  = 1'b0;
  endtask

  initial begin
    // Reset state.
    #1;
    check("reset_async", obs_vec(), 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", obs_vec(), 5'b00000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    stream("n5_ack2",      5,  1, 0, 0, 4'd0, 1'b0);
    stream("n0_ack0",      0,  0, 0, 0, 4'd0, 1'b0);
    stream("n15_timeout", 15, -1, 0, 0, 4'd0, 1'b0);
    stream("err_clear",    2,  0, 0, 0, 4'd0, 1'b0);
    stream("n3_restart9",  3,  0, 0, 3, 4'd9, 1'b0);
    stream("abort_emit",   4,  0, 4, 0, 4'd0, 1'b0);
    stream("abort_strt",   4,  0, 2, 0, 4'd0, 1'b0);
    stream("n1_g_w_start", 1,  0, 0, 0, 4'd0, 1'b1);
    stream("n1_ack_last",  1, TIMEOUT - 1, 0, 0, 4'd0, 1'b0);
    stream("n1_ack_first", 1,  0, 0, 0, 4'd0, 1'b0);

    // Reset mid-stream, then a normal stream.
    cycle("rst_mid strt", 1'b1, 4'd6, 1'b0, 5'b10100);
    cycle("rst_mid p1",   1'b0, 4'd0, 1'b0, 5'b01100);
    cycle("rst_mid p2",   1'b0, 4'd0, 1'b0, {1'b0, !GAP, 3'b100});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid async", obs_vec(), 5'b00000);
    @(posedge clk);
    #1;
    check("rst_mid held", obs_vec(), 5'b00000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stream("after_rst_n2", 2, 0, 0, 0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
